// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - arbitrates instruction/data requests onto a single-port RAM
module mem_req_arbiter #(
    parameter int MAX_RETRY = 3,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       dstore,
    input  logic              halt,
    output logic              ihit,
    output logic              dhit,
    output logic [31:0]       imemload,
    output logic [31:0]       dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic [1:0]        ramstate,
    output logic              err
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam logic [31:0] FAIL_WORD  = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IREQ = 2'd1,
        DREQ = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         store_q, store_d;
    logic                ihit_q, ihit_d;
    logic                dhit_q, dhit_d;
    logic [31:0]         imem_q, imem_d;
    logic [31:0]         dmem_q, dmem_d;
    logic                err_q, err_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        store_d = store_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        imem_d  = imem_q;
        dmem_d  = dmem_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                // Data first so a load/store retires before the next fetch.
                if (dREN || dWEN) begin
                    state_d = DREQ;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                end else if (iREN && !halt) begin
                    state_d = IREQ;
                    addr_d  = iaddr;
                    wr_d    = 1'b0;
                end
            end
            IREQ, DREQ: begin
                if (ramstate == RAM_ACCESS) begin
                    state_d = DONE;
                    if (state_q == IREQ) begin
                        ihit_d = 1'b1;
                        imem_d = ramload;
                    end else begin
                        dhit_d = 1'b1;
                        if (!wr_q) dmem_d = ramload;
                    end
                end else if (ramstate == RAM_ERROR) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                    end else begin
                        // Out of retries: complete the handshake so the core is not stuck.
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (state_q == IREQ) begin
                            ihit_d = 1'b1;
                            imem_d = FAIL_WORD;
                        end else begin
                            dhit_d = 1'b1;
                            if (!wr_q) dmem_d = FAIL_WORD;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                retry_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            retry_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            imem_q  <= '0;
            dmem_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            imem_q  <= imem_d;
            dmem_q  <= dmem_d;
            err_q   <= err_d;
        end
    end

    assign ramREN   = (state_q == IREQ) || ((state_q == DREQ) && !wr_q);
    assign ramWEN   = (state_q == DREQ) && wr_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign imemload = imem_q;
    assign dmemload = dmem_q;
    assign err      = err_q;

endmodule
